// File: rtl/rv_multicycle_ctrl_alu_if.sv
// Instruction-field, operand and control/result bundle between the multicycle
// control/ALU slice (slave) and the surrounding datapath (master).
interface rv_multicycle_ctrl_alu_if;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        pc_write;
   logic        ir_write;
   logic        pc_src;
   logic        branch;
   logic        reg_write;
   logic        mem_write;
   logic [1:0]  adr_src;
   logic [2:0]  alu_src_a;
   logic [2:0]  alu_src_b;
   logic [2:0]  result_src;
   logic [3:0]  alu_control;
   logic [31:0] alu_result;
   logic        zero;
   logic [3:0]  state;

   modport master (
      output op, funct3, funct7, src_a, src_b,
      input  pc_write, ir_write, pc_src, branch, reg_write, mem_write,
      input  adr_src, alu_src_a, alu_src_b, result_src, alu_control,
      input  alu_result, zero, state
   );

   modport slave (
      input  op, funct3, funct7, src_a, src_b,
      output pc_write, ir_write, pc_src, branch, reg_write, mem_write,
      output adr_src, alu_src_a, alu_src_b, result_src, alu_control,
      output alu_result, zero, state
   );
endinterface

// File: rtl/rv_multicycle_ctrl_alu.sv
// Multicycle RV32I control slice: Moore main FSM with registered control
// outputs, ALU-control decoder and a combinational 32-bit ALU.
module rv_multicycle_ctrl_alu (
   input  logic                      clk,
   input  logic                      resetn,
   rv_multicycle_ctrl_alu_if.slave   bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JALR     = 4'd10,
      S_JUMP     = 4'd11,
      S_LINK     = 4'd12,
      S_LUI      = 4'd13,
      S_AUIPC    = 4'd14
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       pc_src;
      logic       branch;
      logic       reg_write;
      logic       mem_write;
      logic [1:0] adr_src;
      logic [2:0] src_a;
      logic [2:0] src_b;
      logic [2:0] result_src;
      logic [1:0] alu_op;
      logic       is_imm;
   } ctrl_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_NE   = 4'b1010;
   localparam logic [3:0] ALU_LT   = 4'b1011;
   localparam logic [3:0] ALU_GE   = 4'b1100;
   localparam logic [3:0] ALU_LTU  = 4'b1101;
   localparam logic [3:0] ALU_GEU  = 4'b1110;
   localparam logic [3:0] ALU_ONE  = 4'b1111;

   // Control word for a state; funct3 only matters for the load width in MEMWB.
   function automatic ctrl_t decode_ctrl(input state_t s, input logic [2:0] f3);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.src_b = 3'd1; end
         S_DECODE:   begin c.src_a = 3'd2; c.src_b = 3'd2; end
         S_MEMADR:   begin c.src_a = 3'd1; c.src_b = 3'd2; end
         S_MEMREAD:  c.adr_src = 2'd1;
         S_MEMWB: begin
            c.reg_write = 1'b1;
            case (f3)
               3'b000:  c.result_src = 3'd6;
               3'b001:  c.result_src = 3'd5;
               3'b100:  c.result_src = 3'd4;
               3'b101:  c.result_src = 3'd3;
               default: c.result_src = 3'd1;
            endcase
         end
         S_MEMWRITE: begin c.adr_src = 2'd1; c.mem_write = 1'b1; end
         S_EXECR:    begin c.src_a = 3'd1; c.alu_op = 2'b10; end
         S_EXECI:    begin c.src_a = 3'd1; c.src_b = 3'd2; c.alu_op = 2'b10; c.is_imm = 1'b1; end
         S_ALUWB:    c.reg_write = 1'b1;
         S_BRANCH:   begin c.src_a = 3'd1; c.alu_op = 2'b01; c.pc_src = 1'b1; c.branch = 1'b1; end
         S_JALR:     begin c.src_a = 3'd1; c.src_b = 3'd2; end
         S_JUMP:     begin c.src_a = 3'd3; c.src_b = 3'd3; c.pc_src = 1'b1; end
         S_LINK:     begin c.src_a = 3'd2; c.src_b = 3'd1; end
         S_LUI:      begin c.src_a = 3'd3; c.src_b = 3'd2; end
         S_AUIPC:    begin c.src_a = 3'd2; c.src_b = 3'd2; end
         default:    c = '0;
      endcase
      return c;
   endfunction

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_BR:             state_d = S_BRANCH;
               OP_JAL:            state_d = S_JUMP;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECR, S_EXECI, S_LINK, S_LUI, S_AUIPC: state_d = S_ALUWB;
         S_JALR:    state_d = S_JUMP;
         S_JUMP:    state_d = S_LINK;
         default:   state_d = S_FETCH;
      endcase
      ctrl_d = decode_ctrl(state_d, bus.funct3);
   end

   // Controls are registered alongside the state so they are glitch-free Moore outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_FETCH;
         ctrl_q  <= decode_ctrl(S_FETCH, 3'd0);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Write enables are held low asynchronously for as long as reset is asserted.
   assign bus.pc_write   = ctrl_q.pc_write  & resetn;
   assign bus.ir_write   = ctrl_q.ir_write  & resetn;
   assign bus.reg_write  = ctrl_q.reg_write & resetn;
   assign bus.mem_write  = ctrl_q.mem_write & resetn;
   assign bus.pc_src     = ctrl_q.pc_src;
   assign bus.branch     = ctrl_q.branch;
   assign bus.adr_src    = ctrl_q.adr_src;
   assign bus.alu_src_a  = ctrl_q.src_a;
   assign bus.alu_src_b  = ctrl_q.src_b;
   assign bus.result_src = ctrl_q.result_src;
   assign bus.state      = state_q;

   logic [3:0] alu_control;

   always_comb begin
      alu_control = ALU_ADD;
      case (ctrl_q.alu_op)
         2'b01: begin
            case (bus.funct3)
               3'b000:  alu_control = ALU_SUB;
               3'b001:  alu_control = ALU_NE;
               3'b100:  alu_control = ALU_LT;
               3'b101:  alu_control = ALU_GE;
               3'b110:  alu_control = ALU_LTU;
               3'b111:  alu_control = ALU_GEU;
               default: alu_control = ALU_ONE;
            endcase
         end
         2'b10: begin
            case (bus.funct3)
               3'b000:  alu_control = (!ctrl_q.is_imm && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = bus.funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

   assign bus.alu_control = alu_control;

   logic signed [31:0] a_s, b_s;
   logic        [4:0]  shamt;
   logic        [31:0] alu_y;
   logic               unused_funct7;

   assign a_s           = $signed(bus.src_a);
   assign b_s           = $signed(bus.src_b);
   assign shamt         = bus.src_b[4:0];
   assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

   // Branch compares return 0 when taken so the zero flag doubles as "take branch".
   always_comb begin
      alu_y = 32'd1;
      case (alu_control)
         ALU_ADD:  alu_y = bus.src_a + bus.src_b;
         ALU_SUB:  alu_y = bus.src_a - bus.src_b;
         ALU_AND:  alu_y = bus.src_a & bus.src_b;
         ALU_OR:   alu_y = bus.src_a | bus.src_b;
         ALU_XOR:  alu_y = bus.src_a ^ bus.src_b;
         ALU_SLL:  alu_y = bus.src_a << shamt;
         ALU_SRL:  alu_y = bus.src_a >> shamt;
         ALU_SRA:  alu_y = $unsigned(a_s >>> shamt);
         ALU_SLT:  alu_y = {31'd0, a_s < b_s};
         ALU_SLTU: alu_y = {31'd0, bus.src_a < bus.src_b};
         ALU_NE:   alu_y = {31'd0, bus.src_a == bus.src_b};
         ALU_LT:   alu_y = {31'd0, a_s >= b_s};
         ALU_GE:   alu_y = {31'd0, a_s < b_s};
         ALU_LTU:  alu_y = {31'd0, bus.src_a >= bus.src_b};
         ALU_GEU:  alu_y = {31'd0, bus.src_a < bus.src_b};
         default:  alu_y = 32'd1;
      endcase
   end

   assign bus.alu_result = alu_y;
   assign bus.zero       = (alu_y == 32'd0);

endmodule

// File: tb/tb_rv_multicycle_ctrl_alu.sv
// Randomized bench for rv_multicycle_ctrl_alu: a tiny operand-mux model feeds
// the ALU each cycle and a reference model predicts paths, strobes and results.
module tb_rv_multicycle_ctrl_alu;
   logic clk;
   logic resetn;
   int   errors;
   int   checks;

   localparam logic [31:0] PC_V     = 32'h0000_1000;
   localparam logic [6:0]  OP_LOAD  = 7'b0000011;
   localparam logic [6:0]  OP_STORE = 7'b0100011;
   localparam logic [6:0]  OP_R     = 7'b0110011;
   localparam logic [6:0]  OP_I     = 7'b0010011;
   localparam logic [6:0]  OP_BR    = 7'b1100011;
   localparam logic [6:0]  OP_JAL   = 7'b1101111;
   localparam logic [6:0]  OP_JALR  = 7'b1100111;
   localparam logic [6:0]  OP_LUI   = 7'b0110111;
   localparam logic [6:0]  OP_AUIPC = 7'b0010111;

   rv_multicycle_ctrl_alu_if bus ();

   rv_multicycle_ctrl_alu dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observations of one instruction, one entry per cycle.
   logic [3:0]  st_obs  [16];
   logic [31:0] res_obs [16];
   logic        zero_obs[16];
   logic        rw_obs  [16];
   logic        mw_obs  [16];
   logic        pcs_obs [16];
   logic        br_obs  [16];
   logic [1:0]  adr_obs [16];
   logic [2:0]  rs_obs  [16];
   logic [3:0]  ac_obs  [16];
   int          n_obs;
   string       path;

   // RV32I arithmetic semantics.
   function automatic logic [31:0] ref_arith(input logic [2:0] f3, input logic alt,
                                             input logic is_imm, input logic [31:0] a,
                                             input logic [31:0] b);
      case (f3)
         3'd0: return (alt && !is_imm) ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] ref_rs(input logic [2:0] f3);
      case (f3)
         3'b000: return 3'd6;
         3'b001: return 3'd5;
         3'b100: return 3'd4;
         3'b101: return 3'd3;
         default: return 3'd1;
      endcase
   endfunction

   function automatic string ref_path(input logic [6:0] o);
      case (o)
         OP_LOAD:  return "0.1.2.3.4.0.";
         OP_STORE: return "0.1.2.5.0.";
         OP_R:     return "0.1.6.8.0.";
         OP_I:     return "0.1.7.8.0.";
         OP_BR:    return "0.1.9.0.";
         OP_JAL:   return "0.1.11.12.8.0.";
         OP_JALR:  return "0.1.10.11.12.8.0.";
         OP_LUI:   return "0.1.13.8.0.";
         OP_AUIPC: return "0.1.14.8.0.";
         default:  return "0.1.0.";
      endcase
   endfunction

   // Runs one instruction from FETCH back to FETCH, acting as the operand muxes.
   task automatic trace(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
      logic [31:0] sa, sb;
      path  = "";
      n_obs = 0;
      bus.op = o; bus.funct3 = f3; bus.funct7 = f7;
      for (int c = 0; c < 12; c++) begin
         case (bus.alu_src_a)
            3'd0, 3'd2: sa = PC_V;
            3'd1:       sa = a;
            default:    sa = 32'd0;
         endcase
         case (bus.alu_src_b)
            3'd0:    sb = b;
            3'd1:    sb = 32'd4;
            3'd2:    sb = imm;
            default: sb = 32'd0;
         endcase
         bus.src_a = sa; bus.src_b = sb;
         #1;
         st_obs[c] = bus.state;   res_obs[c] = bus.alu_result; zero_obs[c] = bus.zero;
         rw_obs[c] = bus.reg_write; mw_obs[c] = bus.mem_write;   pcs_obs[c]  = bus.pc_src;
         br_obs[c] = bus.branch;  adr_obs[c] = bus.adr_src;    rs_obs[c]   = bus.result_src;
         ac_obs[c] = bus.alu_control;
         path  = {path, $sformatf("%0d.", bus.state)};
         n_obs = c + 1;
         if (c > 0 && bus.state == 4'd0) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b1; bus.op = OP_R; bus.funct3 = 3'd0; bus.funct7 = 7'd0;
      bus.src_a = 32'd0; bus.src_b = 32'd0;
      #1 resetn = 1'b0;
      #1;
      checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
      checks++; if ({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== 4'b0)
         begin errors++; $display("FAIL reset_we: got %b want 0000", {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}); end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
      checks++; if ({bus.pc_write, bus.ir_write, bus.adr_src} !== 4'b1100)
         begin errors++; $display("FAIL reset_release: got %b want 1100", {bus.pc_write, bus.ir_write, bus.adr_src}); end
      // Advance into EXECR, then reset mid-instruction.
      repeat (2) @(negedge clk);
      checks++; if (bus.state !== 4'd6) begin errors++; $display("FAIL pre_reset_state: got %0d want 6", bus.state); end
      resetn = 1'b0;
      #1;
      checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL midreset_state: got %0d want 0", bus.state); end
      @(negedge clk);
      checks++; if ({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== 4'b0)
         begin errors++; $display("FAIL midreset_we: got %b want 0000", {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}); end
      resetn = 1'b1;
      #1;
      checks++; if ({bus.state, bus.pc_write, bus.ir_write, bus.adr_src} !== 8'b0000_1100)
         begin errors++; $display("FAIL midreset_release: got %b want 00001100", {bus.state, bus.pc_write, bus.ir_write, bus.adr_src}); end
   endtask

   task automatic test_rtype();
      logic [31:0] a, b, exp;
      logic [2:0]  f3;
      logic [6:0]  f7;
      for (int k = 0; k < 24; k++) begin
         if (k == 0) begin a = 32'd5; b = 32'd7; f3 = 3'd0; f7 = 7'h20; end
         else begin
            a = $urandom; b = $urandom; f3 = 3'($urandom_range(0, 7));
            f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         end
         trace(OP_R, f3, f7, a, b, 32'd0);
         checks++; if (path != ref_path(OP_R)) begin errors++; $display("FAIL r_path: got %s want %s", path, ref_path(OP_R)); end
         for (int i = 0; i < n_obs; i++) begin
            if (st_obs[i] == 4'd6) begin
               exp = ref_arith(f3, f7[5], 1'b0, a, b);
               checks++; if (res_obs[i] !== exp) begin errors++; $display("FAIL r_result f3=%0d f7=%h: got %h want %h", f3, f7, res_obs[i], exp); end
            end
            checks++; if (rw_obs[i] !== (st_obs[i] == 4'd8)) begin errors++; $display("FAIL r_reg_write st=%0d: got %b want %b", st_obs[i], rw_obs[i], st_obs[i] == 4'd8); end
         end
         if (k == 0) begin
            checks++; if (ac_obs[2] !== 4'b0001) begin errors++; $display("FAIL r_sub_ctrl: got %b want 0001", ac_obs[2]); end
            checks++; if (res_obs[2] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL r_sub_value: got %h want fffffffe", res_obs[2]); end
         end
      end
   endtask

   task automatic test_itype();
      logic [31:0] a, imm, exp;
      logic [2:0]  f3;
      logic [6:0]  f7;
      for (int k = 0; k < 24; k++) begin
         case (k)
            0: begin a = 32'h8000_0000; imm = 32'd4; f3 = 3'd5; f7 = 7'h20; end
            1: begin a = 32'd10; imm = 32'd3; f3 = 3'd0; f7 = 7'h20; end
            default: begin
               a = $urandom; imm = $urandom; f3 = 3'($urandom_range(0, 7));
               f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
         endcase
         trace(OP_I, f3, f7, a, imm, imm);
         checks++; if (path != ref_path(OP_I)) begin errors++; $display("FAIL i_path: got %s want %s", path, ref_path(OP_I)); end
         exp = ref_arith(f3, f7[5], 1'b1, a, imm);
         checks++; if (res_obs[2] !== exp) begin errors++; $display("FAIL i_result f3=%0d f7=%h: got %h want %h", f3, f7, res_obs[2], exp); end
         if (k == 0) begin
            checks++; if ({ac_obs[2], res_obs[2]} !== {4'b0111, 32'hF800_0000})
               begin errors++; $display("FAIL i_sra: got %b/%h want 0111/f8000000", ac_obs[2], res_obs[2]); end
         end
         if (k == 1) begin
            checks++; if ({ac_obs[2], res_obs[2]} !== {4'b0000, 32'd13})
               begin errors++; $display("FAIL i_addi_alt: got %b/%h want 0000/0000000d", ac_obs[2], res_obs[2]); end
         end
      end
   endtask

   task automatic test_load_store();
      logic [2:0] f3_tab [7];
      logic [31:0] a, imm;
      int mw_cnt;
      f3_tab = '{3'd2, 3'd0, 3'd1, 3'd4, 3'd5, 3'd3, 3'd6};
      for (int k = 0; k < 7; k++) begin
         a = $urandom; imm = $urandom;
         trace(OP_LOAD, f3_tab[k], 7'd0, a, 32'd0, imm);
         checks++; if (path != ref_path(OP_LOAD)) begin errors++; $display("FAIL ld_path: got %s want %s", path, ref_path(OP_LOAD)); end
         checks++; if (res_obs[2] !== a + imm) begin errors++; $display("FAIL ld_addr: got %h want %h", res_obs[2], a + imm); end
         checks++; if (adr_obs[3] !== 2'd1) begin errors++; $display("FAIL ld_adr_src: got %0d want 1", adr_obs[3]); end
         checks++; if ({rw_obs[4], rs_obs[4]} !== {1'b1, ref_rs(f3_tab[k])})
            begin errors++; $display("FAIL ld_wb f3=%0d: got %b/%0d want 1/%0d", f3_tab[k], rw_obs[4], rs_obs[4], ref_rs(f3_tab[k])); end
      end
      for (int k = 0; k < 4; k++) begin
         a = $urandom; imm = $urandom;
         trace(OP_STORE, 3'd2, 7'd0, a, $urandom, imm);
         checks++; if (path != ref_path(OP_STORE)) begin errors++; $display("FAIL st_path: got %s want %s", path, ref_path(OP_STORE)); end
         mw_cnt = 0;
         for (int i = 0; i < n_obs; i++) if (mw_obs[i]) mw_cnt++;
         checks++; if (mw_cnt != 1) begin errors++; $display("FAIL st_mw_count: got %0d want 1", mw_cnt); end
         checks++; if ({mw_obs[3], adr_obs[3], rw_obs[3]} !== 4'b1010)
            begin errors++; $display("FAIL st_strobes: got %b want 1010", {mw_obs[3], adr_obs[3], rw_obs[3]}); end
      end
   endtask

   task automatic test_branches();
      logic [2:0]  f3_tab [6];
      logic [2:0]  f3;
      logic [31:0] a, b, exp;
      logic        tk;
      f3_tab = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      for (int k = 0; k < 24; k++) begin
         case (k)
            0: begin f3 = 3'd4; a = 32'hFFFF_FFFF; b = 32'd1; end
            1: begin f3 = 3'd7; a = 32'hFFFF_FFFF; b = 32'd1; end
            2: begin f3 = 3'd1; a = 32'h1234_5678; b = 32'h1234_5678; end
            3: begin f3 = 3'd2; a = 32'd3; b = 32'd3; end
            default: begin
               f3 = f3_tab[$urandom_range(0, 5)]; a = $urandom;
               b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            end
         endcase
         trace(OP_BR, f3, 7'd0, a, b, 32'd0);
         checks++; if (path != ref_path(OP_BR)) begin errors++; $display("FAIL br_path: got %s want %s", path, ref_path(OP_BR)); end
         tk  = (k == 1 || k == 0) ? 1'b1 : ref_taken(f3, a, b);
         exp = (f3 == 3'd0) ? a - b : (tk ? 32'd0 : 32'd1);
         checks++; if ({zero_obs[2], res_obs[2]} !== {tk, exp})
            begin errors++; $display("FAIL br_cmp f3=%0d a=%h b=%h: got %b/%h want %b/%h", f3, a, b, zero_obs[2], res_obs[2], tk, exp); end
         checks++; if ({pcs_obs[2], br_obs[2], pcs_obs[1], br_obs[1]} !== 4'b1100)
            begin errors++; $display("FAIL br_strobes: got %b want 1100", {pcs_obs[2], br_obs[2], pcs_obs[1], br_obs[1]}); end
      end
   endtask

   task automatic test_jumps();
      logic [31:0] a, imm;
      a = $urandom; imm = $urandom;
      trace(OP_JAL, 3'd0, 7'd0, a, 32'd0, imm);
      checks++; if (path != ref_path(OP_JAL)) begin errors++; $display("FAIL jal_path: got %s want %s", path, ref_path(OP_JAL)); end
      checks++; if ({zero_obs[2], pcs_obs[2]} !== 2'b11) begin errors++; $display("FAIL jal_jump: got %b want 11", {zero_obs[2], pcs_obs[2]}); end
      checks++; if (res_obs[3] !== PC_V + 32'd4) begin errors++; $display("FAIL jal_link: got %h want %h", res_obs[3], PC_V + 32'd4); end
      checks++; if (rw_obs[4] !== 1'b1) begin errors++; $display("FAIL jal_wb: got %b want 1", rw_obs[4]); end
      trace(OP_JALR, 3'd0, 7'd0, a, 32'd0, imm);
      checks++; if (path != ref_path(OP_JALR)) begin errors++; $display("FAIL jalr_path: got %s want %s", path, ref_path(OP_JALR)); end
      checks++; if (res_obs[2] !== a + imm) begin errors++; $display("FAIL jalr_target: got %h want %h", res_obs[2], a + imm); end
      checks++; if ({zero_obs[3], pcs_obs[3]} !== 2'b11) begin errors++; $display("FAIL jalr_jump: got %b want 11", {zero_obs[3], pcs_obs[3]}); end
      trace(7'b0001111, 3'd0, 7'd0, a, 32'd0, imm);
      checks++; if (path != ref_path(7'b0001111)) begin errors++; $display("FAIL nop_path: got %s want %s", path, ref_path(7'b0001111)); end
      trace(OP_LUI, 3'd0, 7'd0, a, 32'd0, imm);
      checks++; if (path != ref_path(OP_LUI)) begin errors++; $display("FAIL lui_path: got %s want %s", path, ref_path(OP_LUI)); end
      checks++; if (res_obs[2] !== imm) begin errors++; $display("FAIL lui_value: got %h want %h", res_obs[2], imm); end
      trace(OP_AUIPC, 3'd0, 7'd0, a, 32'd0, imm);
      checks++; if (path != ref_path(OP_AUIPC)) begin errors++; $display("FAIL auipc_path: got %s want %s", path, ref_path(OP_AUIPC)); end
      checks++; if (res_obs[2] !== PC_V + imm) begin errors++; $display("FAIL auipc_value: got %h want %h", res_obs[2], PC_V + imm); end
      checks++; if (res_obs[1] !== PC_V + imm) begin errors++; $display("FAIL decode_target: got %h want %h", res_obs[1], PC_V + imm); end
      checks++; if (res_obs[0] !== PC_V + 32'd4) begin errors++; $display("FAIL fetch_pc4: got %h want %h", res_obs[0], PC_V + 32'd4); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_rtype();
      test_itype();
      test_load_store();
      test_branches();
      test_jumps();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/rv_multicycle_ctrl_alu.md
Name: rv_multicycle_ctrl_alu

Overview:
- Control and execute slice of a multicycle RV32I core: main control FSM, ALU-control decoder and 32-bit ALU in one block.
- Consumes IR fields (op, funct3, funct7) and the two ALU operands selected by the external datapath muxes.
- Produces every datapath control strobe/select plus the ALU result and zero flag.
- The external PC loads when (pc_src & zero) | pc_write, taking the registered alu_result if pc_src & zero, else PC+4.

Parameters:
- none

Ports:
- Interface rule: one clock; reset is asynchronous and active-low (clk, resetn).
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- op  in  7  ir[6:0]
- funct3  in  3  ir[14:12]
- funct7  in  7  ir[31:25]
- src_a  in  32  ALU operand A
- src_b  in  32  ALU operand B
- pc_write  out  1  load PC with PC+4
- ir_write  out  1  latch IR and old_pc
- pc_src  out  1  PC takes alu_result when zero=1
- branch  out  1  high in BRANCH state
- reg_write  out  1  register-file write
- mem_write  out  1  memory write enable
- adr_src  out  2  memory address: 0 PC, 1 alu_result register
- alu_src_a  out  3  0 PC, 1 a_reg, 2 old_pc, 3 zero, 4 mdr, 5 alu_result
- alu_src_b  out  3  0 b_reg, 1 const 4, 2 immediate, 3 zero
- result_src  out  3  0 alu_result, 1 load word, 3 zext half, 4 zext byte, 5 sext half, 6 sext byte
- alu_control  out  4  decoded ALU operation
- alu_result  out  32  combinational ALU result
- zero  out  1  alu_result == 0
- state  out  4  current FSM state (debug)

Behaviour:
- Moore FSM. Outputs depend only on state; next state depends on op. Unlisted outputs are 0.
- While resetn=0: state=FETCH; pc_write, ir_write, reg_write and mem_write are forced to 0.
- Unused state codes 15 go to FETCH.
- FETCH(0): adr_src=0, ir_write=1, pc_write=1, srcA=0, srcB=1, alu_op=00. Next: DECODE.
- DECODE(1): srcA=2, srcB=2, ADD, so the alu_result register holds old_pc+imm. Next by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JUMP
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> FETCH (no-op)
- MEMADR(2): srcA=1, srcB=2, ADD. Load goes to MEMREAD; store goes to MEMWRITE.
- MEMREAD(3): adr_src=1. Next: MEMWB.
- MEMWB(4): reg_write=1. result_src by funct3: 010->1, 000->6, 001->5, 100->4, 101->3, other->1. Next: FETCH.
- MEMWRITE(5): adr_src=1, mem_write=1. Full word only. Next: FETCH.
- EXECR(6): srcA=1, srcB=0, alu_op=10, is_imm=0. Next: ALUWB.
- EXECI(7): same as EXECR but srcB=2, is_imm=1. Next: ALUWB.
- ALUWB(8): reg_write=1, result_src=0. Next: FETCH.
- BRANCH(9): srcA=1, srcB=0, alu_op=01, pc_src=1, branch=1. Next: FETCH.
- JALR(10): srcA=1, srcB=2, ADD. No LSB clearing of the target. Next: JUMP.
- JUMP(11): srcA=3, srcB=3, ADD, so zero=1; pc_src=1. Next: LINK.
- LINK(12): srcA=2, srcB=1, ADD. Next: ALUWB.
- LUI(13): srcA=3, srcB=2, ADD. Next: ALUWB.
- AUIPC(14): srcA=2, srcB=2, ADD. Next: ALUWB.
- Decoder, alu_op=00 or 11: ADD.
- Decoder, alu_op=01, by funct3: 000 SUB, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU, 010/011 ONE (branch never taken).
- Decoder, alu_op=10, by funct3:
  - 000: SUB if !is_imm & funct7[5], else ADD
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA if funct7[5], else SRL
  - 110: OR
  - 111: AND
- ALU codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU (both give 1/0).
- Branch-compare codes give 0 when the branch is taken, else 1: 1010 NE (a!=b), 1011 LT (signed a<b), 1100 GE (signed a>=b), 1101 LTU (a<b unsigned), 1110 GEU (a>=b unsigned).
- 1111 ONE: result=1.
- ALU is combinational. Add/sub wrap modulo 2^32. Shift amount is src_b[4:0].

Test Plan:
- Reset: resetn=0 mid-instruction -> state=0 and all write enables 0. After release, first cycle has pc_write=1, ir_write=1, adr_src=0.
- R-type: op=0110011, funct7=0100000, funct3=000 -> states 0,1,6,8,0. In EXECR alu_control=0001; src_a=5, src_b=7 gives alu_result=0xFFFFFFFE. reg_write=1 in ALUWB only.
- I-type: op=0010011, funct3=101, funct7=0100000, src_a=0x80000000, src_b=4 -> alu_control=0111, result=0xF8000000. With funct3=000 and funct7[5]=1 -> ADD, not SUB.
- Load/store: op=0000011, funct3=000 -> states 0,1,2,3,4; result_src=6 in MEMWB. op=0100011 -> 0,1,2,5 with mem_write=1 for exactly one cycle, adr_src=1.
- Branches: BLT with src_a=-1, src_b=1 -> zero=1, pc_src=1. BGEU with same operands -> zero=1. BNE with equal operands -> zero=0. funct3=010 -> zero=0.
- Jumps: JAL -> states 0,1,11,12,8; zero=1 and pc_src=1 in JUMP. JALR -> 0,1,10,11,12,8. Unknown op 0001111 -> 0,1,0.
